// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO onto an 8N1 UART line, LSB first, one pop per frame.
// All outputs are registered; the next frame's pop is decided on the stop bit's last cycle.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic        F_EMPTY_N,
  input  logic [7:0]  FIFO_DATA,
  output logic        READ,
  output logic        TX,
  output logic        BUSY,
  output logic [15:0] FRAMES
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_POP, ST_LOAD, ST_START, ST_DATA, ST_STOP
  } state_t;

  state_t        state, state_d;
  logic [7:0]    shreg, shreg_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [15:0]   frames, frames_d;
  logic          tx_d, read_d, busy_d;
  logic          bit_done;

  assign bit_done = (cnt == LAST);
  assign FRAMES   = frames;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d  = state;
    shreg_d  = shreg;
    cnt_d    = cnt;
    idx_d    = idx;
    frames_d = frames;

    case (state)
      ST_IDLE: if (ENABLE && F_EMPTY_N) state_d = ST_POP;
      ST_POP:  state_d = ST_LOAD;
      ST_LOAD: begin
        shreg_d = FIFO_DATA;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg[7:1]};
          idx_d   = idx + 3'd1;
          if (idx == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          cnt_d    = '0;
          frames_d = frames + 16'd1;
          state_d  = (ENABLE && F_EMPTY_N) ? ST_POP : ST_IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered without a cycle of lag.
    read_d = (state_d == ST_POP);
    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_START)     tx_d = 1'b0;
    else if (state_d == ST_DATA) tx_d = shreg_d[0];
    else                         tx_d = 1'b1;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_IDLE;
      // NOTE: the shift register is a plain datapath register, so resetting it is cheap and keeps TX deterministic.
      shreg  <= '0;
      cnt    <= '0;
      idx    <= '0;
      frames <= '0;
      TX     <= 1'b1;
      READ   <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state  <= state_d;
      shreg  <= shreg_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      frames <= frames_d;
      TX     <= tx_d;
      READ   <= read_d;
      BUSY   <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, timeline-based reference model,
// per-cycle output comparison and a UART receiver for decoded-byte checks.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int CPB     = 4;
  localparam int FRAME_T = 2 + 10 * CPB;  // pop + load + 10 bit times

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic        F_EMPTY_N;
  logic [7:0]  FIFO_DATA = 8'h00;
  logic        READ, TX, BUSY;
  logic [15:0] FRAMES;

  always #5 CLOCK = ~CLOCK;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE(ENABLE), .F_EMPTY_N(F_EMPTY_N),
    .FIFO_DATA(FIFO_DATA), .READ(READ), .TX(TX), .BUSY(BUSY), .FRAMES(FRAMES)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: pushes from the test, pops on READ with data valid the next cycle
  logic [7:0] mem [256];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign F_EMPTY_N = (push_cnt != pop_cnt);

  always @(posedge CLOCK) begin
    if (READ) begin
      FIFO_DATA <= mem[pop_cnt % 256];
      pop_cnt   <= pop_cnt + 1;
    end
  end

  task automatic push(input logic [7:0] d);
    mem[push_cnt % 256] = d;
    push_cnt++;
  endtask

  // Reference model: a transaction is a timeline t = 0 .. FRAME_T-1 after the pop decision
  bit          m_active = 1'b0;
  int          m_t = 0;
  int          m_count = 0;
  logic [7:0]  m_byte = 8'h00;
  logic [15:0] frames_base = 16'h0000;

  always @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_active = 1'b0;
      m_t      = 0;
      m_count  = 0;
    end else if (m_active) begin
      if (m_t == FRAME_T - 1) begin
        m_count++;
        if (ENABLE && F_EMPTY_N) m_t = 0;
        else m_active = 1'b0;
      end else begin
        if (m_t == 0) m_byte = mem[pop_cnt % 256];
        m_t++;
      end
    end else if (ENABLE && F_EMPTY_N) begin
      m_active = 1'b1;
      m_t      = 0;
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge CLOCK) begin
    logic e_tx, e_rd, e_busy;
    int   b;
    e_tx = 1'b1; e_rd = 1'b0; e_busy = 1'b0;
    if (m_active) begin
      e_busy = 1'b1;
      e_rd   = (m_t == 0);
      if (m_t >= 2) begin
        b = (m_t - 2) / CPB;
        if (b == 0)      e_tx = 1'b0;
        else if (b <= 8) e_tx = m_byte[b-1];
        else             e_tx = 1'b1;
      end
    end
    check("cyc_tx", TX, e_tx);
    check("cyc_read", READ, e_rd);
    check("cyc_busy", BUSY, e_busy);
    check("cyc_frames", FRAMES, 16'(frames_base + 16'(m_count)));
  end

  // Monitors: cycle counter, READ timestamps, BUSY gaps between the first and third pop
  int   cyc = 0;
  int   read_times[$];
  int   busy_gap = 0;
  logic [7:0] rx_q[$];

  always @(posedge CLOCK) cyc <= cyc + 1;

  always @(negedge CLOCK) begin
    if (READ) read_times.push_back(cyc);
    if (!BUSY && read_times.size() >= 1 && read_times.size() < 3) busy_gap++;
  end

  // UART receiver sampling mid-bit
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge CLOCK);
      if (RESET_N && TX == 1'b0) begin
        repeat (CPB / 2) @(negedge CLOCK);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLOCK);
          b[i] = TX;
        end
        repeat (CPB) @(negedge CLOCK);
        rx_q.push_back(b);
      end
    end
  end

  function automatic logic [31:0] rx_at(input int i);
    return (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD;
  endfunction

  function automatic logic [31:0] read_gap(input int i);
    return (i < read_times.size()) ? 32'(read_times[i] - read_times[i-1]) : 32'hDEAD;
  endfunction

  task automatic at_mid();
    @(posedge CLOCK);
    #2;
  endtask

  task automatic apply_reset();
    at_mid();
    RESET_N     = 1'b0;
    ENABLE      = 1'b0;
    push_cnt    = pop_cnt;
    frames_base = 16'h0000;
    repeat (3) @(posedge CLOCK);
    #2;
    RESET_N = 1'b1;
    read_times.delete();
    rx_q.delete();
    busy_gap = 0;
  endtask

  task automatic wait_read(input int budget);
    int n = 0;
    while (!READ && n < budget) begin
      @(negedge CLOCK);
      n++;
    end
    check("read_timeout", READ, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (3) @(negedge CLOCK);
    while (BUSY && n < budget) begin
      @(negedge CLOCK);
      n++;
    end
    check("idle_timeout", BUSY, 1'b0);
    at_mid();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset idle: enabled with an empty FIFO for 100 cycles
    repeat (3) @(posedge CLOCK);
    #2;
    RESET_N = 1'b1;
    ENABLE  = 1'b1;
    repeat (100) @(negedge CLOCK);
    check("idle_tx", TX, 1'b1);
    check("idle_busy", BUSY, 1'b0);
    check("idle_frames", FRAMES, 16'h0000);
    check("idle_reads", read_times.size(), 0);

    // Single byte
    apply_reset();
    ENABLE = 1'b1;
    push(8'hA5);
    wait_idle(200);
    check("single_reads", read_times.size(), 1);
    check("single_rx", rx_at(0), 32'h0000_00A5);
    check("single_frames", FRAMES, 16'd1);
    check("single_busy", BUSY, 1'b0);

    // Back-to-back frames, plus a randomized burst
    apply_reset();
    ENABLE = 1'b1;
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_idle(600);
    check("b2b_reads", read_times.size(), 3);
    check("b2b_gap1", read_gap(1), 32'd42);
    check("b2b_gap2", read_gap(2), 32'd42);
    check("b2b_rx0", rx_at(0), 32'h0000_0000);
    check("b2b_rx1", rx_at(1), 32'h0000_00FF);
    check("b2b_rx2", rx_at(2), 32'h0000_003C);
    check("b2b_busy_gap", busy_gap, 0);
    check("b2b_frames", FRAMES, 16'd3);

    begin
      logic [7:0] exp_b[$];
      rx_q.delete();
      for (int i = 0; i < 6; i++) begin
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        exp_b.push_back(d);
        push(d);
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 60)) @(negedge CLOCK);
        at_mid();
      end
      wait_idle(2000);
      check("rand_rx_cnt", rx_q.size(), 6);
      for (int i = 0; i < 6; i++) check("rand_rx", rx_at(i), {24'd0, exp_b[i]});
    end

    // Enable gating
    apply_reset();
    push(8'h11); push(8'h22);
    repeat (30) @(negedge CLOCK);
    check("gate_no_read", read_times.size(), 0);
    at_mid();
    ENABLE = 1'b1;
    wait_read(20);
    repeat (10) @(negedge CLOCK);
    #2;
    ENABLE = 1'b0;
    wait_idle(200);
    repeat (20) @(negedge CLOCK);
    check("gate_reads", read_times.size(), 1);
    check("gate_frames", FRAMES, 16'd1);
    check("gate_use_dw", push_cnt - pop_cnt, 1);
    check("gate_rx", rx_at(0), 32'h0000_0011);

    // Reset during data bit 3 of 0x81
    apply_reset();
    ENABLE = 1'b1;
    push(8'h81);
    wait_read(20);
    repeat (19) @(negedge CLOCK);
    at_mid();
    RESET_N = 1'b0;
    #1;
    check("rst_tx", TX, 1'b1);
    check("rst_busy", BUSY, 1'b0);
    check("rst_frames", FRAMES, 16'h0000);
    repeat (2) @(posedge CLOCK);
    #2;
    RESET_N = 1'b1;
    repeat (12 * CPB) @(negedge CLOCK);
    check("rst_no_reread", read_times.size(), 1);
    check("rst_use_dw", push_cnt - pop_cnt, 0);
    at_mid();
    rx_q.delete();
    push(8'h55);
    wait_idle(200);
    check("rst_rx", rx_at(0), 32'h0000_0055);
    check("rst_frames_after", FRAMES, 16'd1);

    // Counter wrap: preload the frame counter near its limit
    apply_reset();
    force dut.frames = 16'hFFFE;
    frames_base = 16'hFFFE;
    at_mid();
    release dut.frames;
    ENABLE = 1'b1;
    push(8'h5A);
    wait_idle(200);
    check("wrap_ffff", FRAMES, 16'hFFFF);
    push(8'hC3);
    wait_idle(200);
    check("wrap_0000", FRAMES, 16'h0000);
    check("wrap_rx", rx_at(1), 32'h0000_00C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
